// File: rtl/lif_step_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update datapath
// walks all virtual neurons once per timestep, driven by a valid/ready current stream.
module lif_step_scheduler #(
  parameter int NUM_NEURONS       = 4,
  parameter int INPUT_WIDTH       = 8,
  parameter int POTENTIAL_WIDTH   = 16,
  parameter int THRESHOLD         = 300,
  parameter int LEAK_FACTOR       = 4,
  parameter int REFRACTORY_PERIOD = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                step_start,
  input  logic                                clear_state,
  input  logic                                cur_valid,
  output logic                                cur_ready,
  input  logic signed [INPUT_WIDTH-1:0]       current_in,
  output logic [$clog2(NUM_NEURONS)-1:0]      cur_idx,
  output logic                                busy,
  output logic                                step_done,
  output logic [NUM_NEURONS-1:0]              spike_vec,
  input  logic [$clog2(NUM_NEURONS)-1:0]      probe_idx,
  output logic signed [POTENTIAL_WIDTH-1:0]   probe_potential
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int PW    = POTENTIAL_WIDTH;
  localparam int SW    = POTENTIAL_WIDTH + 2;
  localparam int RW    = (REFRACTORY_PERIOD < 1) ? 1 : $clog2(REFRACTORY_PERIOD + 1);

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic signed [SW-1:0] SAT_MAX  = {3'b000, {(PW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN  = {3'b111, {(PW-1){1'b0}}};
  localparam logic signed [PW-1:0] THRESH   = PW'(THRESHOLD);
  localparam logic [RW-1:0]        REFRAC   = RW'(REFRACTORY_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [PW-1:0]    v_q [NUM_NEURONS];
  logic signed [PW-1:0]    v_d [NUM_NEURONS];
  logic [RW-1:0]           r_q [NUM_NEURONS];
  logic [RW-1:0]           r_d [NUM_NEURONS];
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_NEURONS-1:0]  spike_q, spike_d;

  logic                    hs;
  logic signed [PW-1:0]    sel_v, leak, sat_sum;
  logic [RW-1:0]           sel_r;
  logic signed [SW-1:0]    sum;
  logic                    fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (step_start && !clear_state) state_d = S_UPDATE;
      S_UPDATE: if (hs && idx_q == LAST_IDX)    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cur_ready = (state_q == S_UPDATE);
    busy      = (state_q != S_IDLE);
    step_done = (state_q == S_DONE);
  end

  assign hs    = cur_valid && cur_ready;
  assign sel_v = v_q[idx_q];
  assign sel_r = r_q[idx_q];
  assign leak  = sel_v >>> LEAK_FACTOR;

  // Two guard bits keep V + I - leak exact before clamping back to PW bits.
  assign sum = {{2{sel_v[PW-1]}}, sel_v}
             + {{(SW-INPUT_WIDTH){current_in[INPUT_WIDTH-1]}}, current_in}
             - {{2{leak[PW-1]}}, leak};

  always_comb begin
    if (sum > SAT_MAX)      sat_sum = SAT_MAX[PW-1:0];
    else if (sum < SAT_MIN) sat_sum = SAT_MIN[PW-1:0];
    else                    sat_sum = sum[PW-1:0];
  end

  assign fire = (sat_sum >= THRESH);

  // NOTE: every _d gets its hold value first so no path through this block infers a latch;
  // blocking '=' is correct here because this is combinational next-state, not storage.
  always_comb begin
    v_d     = v_q;
    r_d     = r_q;
    idx_d   = idx_q;
    spike_d = spike_q;
    case (state_q)
      S_IDLE: begin
        if (clear_state) begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            v_d[i] = '0;
            r_d[i] = '0;
          end
          spike_d = '0;
        end else if (step_start) begin
          idx_d   = '0;
          spike_d = '0;
        end
      end
      S_UPDATE: begin
        if (hs) begin
          idx_d = idx_q + IDX_W'(1);
          if (sel_r != '0) begin
            r_d[idx_q] = sel_r - RW'(1);
            v_d[idx_q] = '0;
          end else if (fire) begin
            r_d[idx_q]     = REFRAC;
            v_d[idx_q]     = '0;
            spike_d[idx_q] = 1'b1;
          end else begin
            v_d[idx_q] = sat_sum;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the neuron state arrays are flops, not RAM, so they take the synchronous reset
  // like any other register; an aborted step must leave no partially updated neuron.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
      idx_q   <= '0;
      spike_q <= '0;
    end else begin
      v_q     <= v_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      spike_q <= spike_d;
    end
  end

  assign cur_idx         = idx_q;
  assign spike_vec       = spike_q;
  assign probe_potential = v_q[probe_idx];

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Bench for lif_step_scheduler: directed scenarios with literal expectations plus a
// randomized phase, all checked each cycle against a step-level behavioural model.
module tb_lif_step_scheduler;

  localparam int N   = 4;
  localparam int THR = 300;
  localparam int LK  = 4;
  localparam int RP  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              step_start = 1'b0;
  logic              clear_state = 1'b0;
  logic              cur_valid = 1'b0;
  logic signed [7:0] current_in = '0;
  logic [1:0]        probe_idx = '0;
  logic              cur_ready, busy, step_done;
  logic [1:0]        cur_idx;
  logic [N-1:0]      spike_vec;
  logic signed [15:0] probe_potential;

  always #5 clk = ~clk;

  lif_step_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .step_start      (step_start),
    .clear_state     (clear_state),
    .cur_valid       (cur_valid),
    .cur_ready       (cur_ready),
    .current_in      (current_in),
    .cur_idx         (cur_idx),
    .busy            (busy),
    .step_done       (step_done),
    .spike_vec       (spike_vec),
    .probe_idx       (probe_idx),
    .probe_potential (probe_potential)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mpos = -1 idle, 0..N-1 neuron awaiting current, N = done cycle.
  int           mv [N];
  int           mr [N];
  logic [N-1:0] mspk = '0;
  int           mpos = -1;

  function automatic int floor_shift(input int v, input int s);
    int d = 1 << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int clamp16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  initial for (int i = 0; i < N; i++) begin mv[i] = 0; mr[i] = 0; end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin mv[i] = 0; mr[i] = 0; end
      mspk = '0;
      mpos = -1;
    end else if (mpos == -1) begin
      if (clear_state) begin
        for (int i = 0; i < N; i++) begin mv[i] = 0; mr[i] = 0; end
        mspk = '0;
      end else if (step_start) begin
        mpos = 0;
        mspk = '0;
      end
    end else if (mpos == N) begin
      mpos = -1;
    end else if (cur_valid) begin
      if (mr[mpos] > 0) begin
        mr[mpos] = mr[mpos] - 1;
        mv[mpos] = 0;
      end else begin
        int s;
        s = clamp16(mv[mpos] + int'(current_in) - floor_shift(mv[mpos], LK));
        if (s >= THR) begin
          mspk[mpos] = 1'b1;
          mv[mpos]   = 0;
          mr[mpos]   = RP;
        end else begin
          mv[mpos] = s;
        end
      end
      mpos = mpos + 1;
    end
  end

  // Compare process: outputs sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    check("busy",      busy,            mpos != -1);
    check("cur_ready", cur_ready,       (mpos >= 0) && (mpos < N));
    check("step_done", step_done,       mpos == N);
    check("spike_vec", spike_vec,       mspk);
    check("probe",     probe_potential, mv[probe_idx]);
    if (mpos >= 0 && mpos < N) check("cur_idx", cur_idx, mpos);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step_start = 1'b0; clear_state = 1'b0; cur_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  logic signed [7:0] cur_tab [N];
  int stall_at  = -1;
  int stall_len = 0;
  logic spam = 1'b0;

  // Runs one timestep; lat = handshake/stall cycles from the start edge to step_done.
  task automatic run_step(output int lat);
    int n = 0;
    int st = 0;
    logic signed [15:0] held = '0;
    step_start = 1'b1;
    cyc();
    step_start = spam;
    while (!step_done && n < 100) begin
      if (int'(cur_idx) == stall_at && st < stall_len) begin
        probe_idx = cur_idx;
        #1;
        if (st == 0) held = probe_potential;
        else begin
          check("stall_idx", cur_idx, stall_at);
          check("stall_v", probe_potential, held);
        end
        cur_valid = 1'b0;
        st++;
      end else begin
        cur_valid  = 1'b1;
        current_in = cur_tab[cur_idx];
      end
      cyc();
      n++;
    end
    cur_valid  = 1'b0;
    step_start = 1'b0;
    if (!step_done) check("step_timeout", 0, 1);
    lat = n;
    cyc();
  endtask

  task automatic probe_all(input string name, input int exp);
    for (int i = 0; i < N; i++) begin
      probe_idx = 2'(i);
      #1;
      check(name, probe_potential, exp);
    end
  endtask

  int exp_v0 [8] = '{127, 247, 0, 0, 0, 0, 0, 127};
  int exp_sp [8] = '{0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    int lat;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_ready", cur_ready, 0);
    check("rst_done", step_done, 0);
    check("rst_spike", spike_vec, 0);
    probe_all("rst_v", 0);

    // Single driven neuron: integrate, fire, refractory, resume.
    cur_tab = '{8'sd127, 8'sd0, 8'sd0, 8'sd0};
    for (int s = 0; s < 8; s++) begin
      run_step(lat);
      probe_idx = 2'd0;
      #1;
      check("lif_v0", probe_potential, exp_v0[s]);
      check("lif_spike", spike_vec, exp_sp[s]);
      if (s == 0) check("lif_latency", lat, 4);
    end

    // Uniform negative drive: leak on negative potentials, no spikes.
    do_reset();
    cur_tab = '{-8'sd64, -8'sd64, -8'sd64, -8'sd64};
    run_step(lat);
    probe_all("neg_step1", -64);
    run_step(lat);
    probe_all("neg_step2", -124);
    check("neg_spike", spike_vec, 0);

    // Stall at neuron 2 for three cycles.
    do_reset();
    cur_tab = '{8'sd10, 8'sd20, 8'sd30, 8'sd40};
    run_step(lat);
    check("nostall_lat", lat, 4);
    stall_at = 2; stall_len = 3;
    run_step(lat);
    check("stall_lat", lat, 7);
    stall_at = -1; stall_len = 0;

    // step_start held through a busy step: exactly one step_done.
    do_reset();
    cur_tab = '{8'sd5, 8'sd5, 8'sd5, 8'sd5};
    spam = 1'b1;
    run_step(lat);
    spam = 1'b0;
    check("spam_lat", lat, 4);
    for (int i = 0; i < 6; i++) begin
      check("spam_no_done", step_done, 0);
      check("spam_idle", busy, 0);
      cyc();
    end

    // Reset mid-step after neurons 0 and 1 are updated.
    do_reset();
    cur_tab = '{8'sd100, 8'sd100, 8'sd100, 8'sd100};
    step_start = 1'b1;
    cyc();
    step_start = 1'b0;
    for (int i = 0; i < 20 && cur_idx != 2'd2; i++) begin
      cur_valid  = 1'b1;
      current_in = cur_tab[cur_idx];
      cyc();
    end
    cur_valid = 1'b0;
    check("abort_reached_idx2", cur_idx, 2);
    probe_idx = 2'd0;
    #1;
    check("abort_v0_before", probe_potential, 100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_idx", cur_idx, 0);
    probe_all("abort_v", 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", step_done, 0);
      cyc();
    end

    // clear_state wins over step_start in IDLE.
    do_reset();
    cur_tab = '{8'sd50, 8'sd60, 8'sd70, 8'sd80};
    run_step(lat);
    probe_idx = 2'd3;
    #1;
    check("clr_pre_v3", probe_potential, 80);
    clear_state = 1'b1;
    step_start  = 1'b1;
    cyc();
    clear_state = 1'b0;
    step_start  = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_spike", spike_vec, 0);
    probe_all("clr_v", 0);
    for (int i = 0; i < 4; i++) begin
      check("clr_no_done", step_done, 0);
      check("clr_idle", busy, 0);
      cyc();
    end

    // Randomized traffic, checked every cycle by the compare process.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst         = ($urandom_range(199) == 0);
      step_start  = ($urandom_range(3) == 0);
      clear_state = ($urandom_range(39) == 0);
      cur_valid   = ($urandom_range(3) != 0);
      current_in  = ($urandom_range(3) != 0) ? 8'($urandom_range(127, 40)) : 8'($urandom);
      probe_idx   = 2'($urandom_range(N - 1));
      cyc();
    end
    rst = 1'b0; step_start = 1'b0; clear_state = 1'b0; cur_valid = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
